// File: rtl/axil_ram_slave.sv
// axil_ram_slave: AXI4-Lite slave backed by a word-addressed RAM.
// Write address and data are accepted in either order, with one write
// able to sit buffered behind a stalled B response. Reads are registered
// with one cycle of latency. Optional macro AXIL_RAM_DECERR_EN returns
// DECERR for accesses at or beyond DEPTH words. Without it, addresses
// wrap and every response is OKAY.
module axil_ram_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,
    input  logic [ADDR_WIDTH-1:0]     awaddr_i,
    input  logic [2:0]                awprot_i,
    input  logic                      awvalid_i,
    output logic                      awready_o,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   wstrb_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    output logic [1:0]                bresp_o,
    output logic                      bvalid_o,
    input  logic                      bready_i,
    input  logic [ADDR_WIDTH-1:0]     araddr_i,
    input  logic [2:0]                arprot_i,
    input  logic                      arvalid_i,
    output logic                      arready_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic [1:0]                rresp_o,
    output logic                      rvalid_o,
    input  logic                      rready_i
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(DEPTH);
`ifdef AXIL_RAM_DECERR_EN
    localparam logic [ADDR_WIDTH-1:0] RANGE_END = ADDR_WIDTH'(DEPTH * STRB_WIDTH);
`endif

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  aw_full_q, aw_full_d;
    logic                  w_full_q, w_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  wr_ok, rd_ok;

    // Readies are forced low while reset is asserted so nothing is accepted then.
    assign awready_o = arstn_i && !aw_full_q;
    assign wready_o  = arstn_i && !w_full_q;
    assign arready_o = arstn_i && (!rvalid_q || rready_i);
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign rvalid_o  = rvalid_q;
    assign rresp_o   = rresp_q;
    assign rdata_o   = rdata_q;

    assign aw_hs = awvalid_i && awready_o;
    assign w_hs  = wvalid_i && wready_o;
    assign ar_hs = arvalid_i && arready_o;

    // Protection bits and unindexed address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{awprot_i, arprot_i, wr_addr, araddr_i};

    // Commit path: a beat arriving this cycle bypasses its holding register,
    // which gives single-cycle write latency and one write per cycle.
    always_comb begin
        wr_addr = aw_full_q ? aw_addr_q : awaddr_i;
        wr_data = w_full_q ? w_data_q : wdata_i;
        wr_strb = w_full_q ? w_strb_q : wstrb_i;
        wr_idx  = wr_addr[ADDR_LSB +: IDX_W];
        rd_idx  = araddr_i[ADDR_LSB +: IDX_W];
`ifdef AXIL_RAM_DECERR_EN
        wr_ok   = (wr_addr < RANGE_END);
        rd_ok   = (araddr_i < RANGE_END);
`else
        wr_ok   = 1'b1;
        rd_ok   = 1'b1;
`endif
        commit  = (aw_full_q || aw_hs) && (w_full_q || w_hs) && (!bvalid_q || bready_i);

        aw_full_d = commit ? 1'b0 : (aw_full_q || aw_hs);
        w_full_d  = commit ? 1'b0 : (w_full_q || w_hs);
        bvalid_d  = bvalid_q && !bready_i;
        bresp_d   = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_ok ? 2'b00 : 2'b11;
        end

        rvalid_d = rvalid_q && !rready_i;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_ok ? 2'b00 : 2'b11;
            rdata_d  = rd_ok ? mem_q[rd_idx] : '0;
        end
    end

    // Control and response registers; everything here is cleared by reset.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Holding registers for a beat that cannot commit on its handshake edge.
    always_ff @(posedge clk_i) begin
        if (aw_hs) aw_addr_q <= awaddr_i;
        if (w_hs) begin
            w_data_q <= wdata_i;
            w_strb_q <= wstrb_i;
        end
    end

    // RAM byte-lane write; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (commit && wr_ok) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wr_strb[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end
endmodule

// File: doc/axil_ram_slave.md
# axil_ram_slave

AXI4-Lite slave memory that terminates the AXI-Lite initiator ports of the DMA datapath (S2MM write traffic, MM2S read traffic) or any other AXI-Lite master in the design. It accepts write address and write data in either order, applies byte strobes to an internal word-addressed RAM and returns write responses. It serves reads with a registered, one-cycle-latency RAM access. It provides a self-contained memory endpoint for DMA loopback benches and small on-chip buffers.

## Interface
- ADDR_WIDTH, 32: AXI-Lite address width.
- DATA_WIDTH, 32: data width; 32 or 64; STRB_WIDTH = DATA_WIDTH/8.
- DEPTH, 1024: number of DATA_WIDTH words; power of two.

- clk_i  in  1  single clock for all channels.
- arstn_i  in  1  reset, asynchronous, active-low.
- awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1  write address channel; awprot is ignored.
- awready  out  1  write address ready.
- wdata/wstrb/wvalid  in  DATA_WIDTH/STRB_WIDTH/1  write data channel.
- wready  out  1  write data ready.
- bresp/bvalid  out  2/1  write response.
- bready  in  1  write response ready.
- araddr/arprot/arvalid  in  ADDR_WIDTH/3/1  read address channel; arprot is ignored.
- arready  out  1  read address ready.
- rdata/rresp/rvalid  out  DATA_WIDTH/2/1  read data channel.
- rready  in  1  read data ready.

## Operation
- Word index = addr[ADDR_LSB +: log2(DEPTH)], with ADDR_LSB = log2(STRB_WIDTH). Low address bits below ADDR_LSB are ignored; unaligned addresses are treated as aligned.
- **Write path.** Two holding registers, AW and W, each with a full flag.
  - awready = !aw_full.
  - wready = !w_full.
  - Each register loads on its handshake, independently of the other; AW before W, W before AW, and both in the same cycle are all legal.
- **Write commit.** Commit occurs when aw_full && w_full && (!bvalid || bready). On the commit edge:
  - each byte lane i with wstrb[i]=1 is written;
  - both full flags clear;
  - bvalid is set and bresp is loaded.
- **B channel.** bvalid holds, with bresp stable, until bready. If bvalid && !bready, the commit is stalled. The AW and W registers may still be filled, which gives at most one write buffered behind the pending B.
- **Read path.** arready = !rvalid || rready.
  - On the AR handshake, RAM is read at the word index; rdata, rresp and rvalid are registered on that edge.
  - rvalid && rready with no new AR clears rvalid on the next edge.
  - rvalid && rready with a new AR in the same cycle keeps rvalid high and loads the new data (back-to-back reads).
- **Simultaneous read and write to the same word on the same edge:** the read returns the pre-write contents.
- **Independence:** write and read paths share no arbitration; both may complete in the same cycle.
- **Strobes:** wstrb = 0 is accepted and answered with OKAY; no bytes are modified.

## Timing
- While arstn_i is low:
  - awready, wready, arready, bvalid and rvalid are 0;
  - bresp, rresp and rdata are 0.
  - RAM contents are not reset.
- First cycle after reset release: awready = wready = arready = 1.
- Write latency: bvalid is visible 1 cycle after the later of the AW and W handshakes, provided B is not stalled.
- Write throughput: one write per cycle when AW and W arrive together and bready = 1.
- Read latency: rvalid and rdata are visible 1 cycle after the AR handshake. Throughput is one read per cycle with rready = 1.
- Reset asserted mid-transaction: all buffered AW/W, pending B and pending R state is discarded immediately. RAM writes already committed persist.

## Configuration
- AXIL_RAM_DECERR_EN
  - **Defined:** an address with addr >= DEPTH*STRB_WIDTH is out of range.
    - An out-of-range write commits no RAM update and returns bresp = 2'b11 (DECERR).
    - An out-of-range read returns rresp = 2'b11 and rdata = 0.
    - In-range accesses return OKAY.
  - **Undefined:** upper address bits are ignored. Addresses wrap modulo DEPTH words and every response is OKAY (2'b00).

## Test plan
- **Write then read, same word:** AW 0x10 with W 0xDEADBEEF and wstrb 0xF in the same cycle, bready = 1.
  - Required: bvalid exactly 1 cycle later with bresp = 0.
  - Follow-up: AR 0x10 -> rvalid 1 cycle later with rdata 0xDEADBEEF.
- **Out-of-order AW/W and B backpressure:**
  - W 0x11223344 is presented 3 cycles before AW 0x20, with bready = 0 for 5 cycles.
  - Required: bvalid is held, then a single B. A second write queued meanwhile is committed only after the first B handshake.
- **Byte strobes:**
  - Step 1: word 0x30 = 0xAABBCCDD.
  - Step 2: write 0x00001100 with wstrb 0x2.
  - Required: reading 0x30 returns 0xAABB11DD.
- **Back-to-back reads with stall:**
  - ARs to 0x0, 0x4 and 0x8 on consecutive cycles, with rready low for 2 cycles in the middle.
  - Required: arready drops while R is stalled, and the data returns in order with no loss or duplication.
- **Range handling:** write and read at address DEPTH*STRB_WIDTH.
  - With AXIL_RAM_DECERR_EN: bresp = rresp = 2'b11, rdata = 0, and word 0 is unchanged.
  - Without the macro: the access aliases word 0 and returns OKAY.
- **Reset mid-operation:**
  - AW accepted, W not yet presented, and an R pending with rready = 0; arstn_i is then pulsed low.
  - Required: bvalid = rvalid = 0 during reset, all readies = 1 after release, and no spurious B or R appears.
